instr_fetch_unit: RTL

Byte-serial instruction fetch stage that sits directly upstream of the single-cycle processor datapath. It reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit words. It tags each word with its PC and buffers it in a small prefetch queue for the execute stage to consume through a valid/ready handshake. A redirect input from branch resolution flushes the queue and restarts fetch at a new PC.

---
 rtl/ifu_pkg.sv | 17 +
 rtl/ifu_if.sv | 28 ++
 rtl/ifu_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package ifu_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    FETCH,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] data;
  } ifq_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory bus, redirect input and execute-stage handshake of the fetch unit.
interface ifu_if
  import ifu_pkg::*;
#(
  parameter int IMEM_AW = 5
);

  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rd;
  logic [7:0]         imem_data;
  logic               redirect_valid;
  logic [WORD_W-1:0]  redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [WORD_W-1:0]  inst_data;
  logic [WORD_W-1:0]  inst_pc;

  modport master (
    output imem_addr, imem_rd, inst_valid, inst_data, inst_pc,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, imem_rd, inst_valid, inst_data, inst_pc,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// Circular prefetch queue of {pc, data} entries with flush, push, pop and occupancy outputs.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  ifq_entry_t               push_entry,
  input  logic                     pop,
  output ifq_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  ifq_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial fetch: assembles big-endian words from byte memory into a prefetch queue.
// Define IFU_STATS_EN to add the stat_fetched / stat_flushes counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 5
) (
  input  logic        clk,
  input  logic        rst,
  ifu_if.master       bus
`ifdef IFU_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e        state_q, state_d;
  logic [WORD_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                push;
  logic                pop;
  logic                can_accept;
  ifq_entry_t          push_entry;
  ifq_entry_t          head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  assign bus.imem_rd   = (state_q == FETCH) & ~rst;
  assign bus.imem_addr = fetch_pc_q[IMEM_AW-1:0] + IMEM_AW'(bidx_q);

  assign pop        = ~fifo_empty & bus.inst_ready & ~bus.redirect_valid;
  assign can_accept = (fifo_count < CW'(DEPTH)) | pop;

  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_data  = head.data;
  assign bus.inst_pc    = head.pc;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bidx_d     = bidx_q;
    word_d     = word_q;
    push       = 1'b0;
    push_entry = '{pc: fetch_pc_q, data: word_q};

    if (bus.redirect_valid) begin
      state_d    = FETCH;
      fetch_pc_d = {bus.redirect_pc[WORD_W-1:2], 2'b00};
      bidx_d     = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          // Big-endian slot: byte index b lands at bit 8*(3-b), and 3-b == ~b for two bits.
          word_d[{~bidx_q, 3'b000} +: 8] = bus.imem_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            push_entry.data = {word_q[WORD_W-1:8], bus.imem_data};
            if (can_accept) begin
              push       = 1'b1;
              fetch_pc_d = fetch_pc_q + WORD_W'(BYTES_PER_WORD);
            end else begin
              state_d = WAIT;
              bidx_d  = bidx_q;
            end
          end
        end
        WAIT: begin
          if (can_accept) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + WORD_W'(BYTES_PER_WORD);
            bidx_d     = '0;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
    end
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  full_matches_count: assert property (
    @(posedge clk) disable iff (rst) fifo_full == (fifo_count == CW'(DEPTH))
  );

`ifdef IFU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      if (push)               stat_fetched <= stat_fetched + 32'd1;
      if (bus.redirect_valid) stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule
